// File: rtl/mcp3002_responder.sv
// mcp3002_responder
//   SPI responder that looks like an MCP3002 2-channel 10-bit ADC to an
//   external master (SPI mode 0,0). It decodes the start/SGL/ODD/MSBF
//   command and returns a 10-bit value taken from parallel sample inputs.
//   The OFDM RX path can then be exercised in loopback without real analog.
// Ports
//   clk, rst              system clock (>= 8x spi_clk), sync active-high reset
//   spi_cs/clk/din        master signals, asynchronous to clk
//   spi_dout, spi_dout_oe data to master and its pad output enable
//   ch0_data, ch1_data    10-bit sample values for CH0 / CH1
//   conv_done             1-clk pulse once B0 has been shifted out
//   conv_cfg              {SGL, ODD, MSBF} of the last decoded command
//   conv_value            value latched for the last decoded command
//   frame_error           1-clk pulse when cs rises mid CMD/DATA
module mcp3002_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_din,
  output logic       spi_dout,
  output logic       spi_dout_oe,
  input  logic [9:0] ch0_data,
  input  logic [9:0] ch1_data,
  output logic       conv_done,
  output logic [2:0] conv_cfg,
  output logic [9:0] conv_value,
  output logic       frame_error
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_CMD        = 3'd2;
  localparam logic [2:0] S_DATA       = 3'd3;
  localparam logic [2:0] S_LSBF       = 3'd4;
  localparam logic [2:0] S_TRAIL      = 3'd5;

  // Synchronizers: all three pins share the same depth so din stays
  // aligned with the synced clock edge that samples it.
  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, din_sync;
  logic                   clk_prev;
  logic                   cs_s, clk_s, din_s, rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      clk_sync <= '0;
      din_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], spi_din};
      clk_prev <= clk_s;
    end
  end

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign din_s = din_sync[SYNC_STAGES-1];
  assign rise  = clk_s & ~clk_prev;
  assign fall  = ~clk_s & clk_prev;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;
  logic        sgl_r, odd_r, msbf_r;
  logic [9:0]  shreg;

  // Value select. With SGL=1 the selected channel is simply in_p; with
  // SGL=0 the difference is taken one bit wider so a negative result is
  // visible in the sign bit and clamps to zero instead of wrapping.
  logic [9:0]  in_p, in_n, sel_value;
  logic [10:0] diff;

  always_comb begin
    in_p      = odd_r ? ch1_data : ch0_data;
    in_n      = odd_r ? ch0_data : ch1_data;
    diff      = {1'b0, in_p} - {1'b0, in_n};
    sel_value = sgl_r ? in_p : (diff[10] ? 10'd0 : diff[9:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      sgl_r       <= 1'b0;
      odd_r       <= 1'b0;
      msbf_r      <= 1'b0;
      shreg       <= 10'd0;
      spi_dout    <= 1'b0;
      spi_dout_oe <= 1'b0;
      conv_done   <= 1'b0;
      conv_cfg    <= 3'd0;
      conv_value  <= 10'd0;
      frame_error <= 1'b0;
    end else begin
      conv_done   <= 1'b0;
      frame_error <= 1'b0;
      if (cs_s) begin
        // cs has priority over any clock edge seen in the same sample.
        // In S_DATA, bit_cnt==10 means B0 is already on the wire.
        if (state == S_CMD || (state == S_DATA && bit_cnt != 4'd10))
          frame_error <= 1'b1;
        state       <= S_IDLE;
        spi_dout    <= 1'b0;
        spi_dout_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT_START;
          S_WAIT_START: begin
            if (rise && din_s) begin
              state   <= S_CMD;
              bit_cnt <= 4'd0;
            end
          end
          S_CMD: begin
            if (rise && bit_cnt < 4'd3) begin
              case (bit_cnt)
                4'd0: sgl_r <= din_s;
                4'd1: odd_r <= din_s;
                default: begin
                  // sgl_r/odd_r are already settled here; the channel
                  // inputs are captured once and never looked at again.
                  msbf_r     <= din_s;
                  shreg      <= sel_value;
                  conv_value <= sel_value;
                  conv_cfg   <= {sgl_r, odd_r, din_s};
                end
              endcase
              bit_cnt <= bit_cnt + 4'd1;
            end else if (fall && bit_cnt == 4'd3) begin
              spi_dout_oe <= 1'b1;
              spi_dout    <= 1'b0;   // null bit
              state       <= S_DATA;
              bit_cnt     <= 4'd0;
            end
          end
          S_DATA: begin
            if (fall) begin
              if (bit_cnt != 4'd10) begin
                spi_dout <= shreg[4'd9 - bit_cnt];
                bit_cnt  <= bit_cnt + 4'd1;
              end else begin
                conv_done <= 1'b1;
                if (msbf_r) begin
                  spi_dout <= 1'b0;
                  state    <= S_TRAIL;
                end else begin
                  // LSB-first repeat starts at B1; B0 was just sent.
                  spi_dout <= shreg[1];
                  bit_cnt  <= 4'd2;
                  state    <= S_LSBF;
                end
              end
            end
          end
          S_LSBF: begin
            if (fall) begin
              if (bit_cnt != 4'd10) begin
                spi_dout <= shreg[bit_cnt];
                bit_cnt  <= bit_cnt + 4'd1;
              end else begin
                spi_dout <= 1'b0;
                state    <= S_TRAIL;
              end
            end
          end
          S_TRAIL: spi_dout <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3002_responder.sv
// Directed bench for mcp3002_responder: a behavioural SPI master shifts
// commands in and collects the returned bits, which are compared against
// hand-computed sample values.
module tb_mcp3002_responder;

  localparam int SYNC = 2;
  localparam int HP   = 80;   // SPI half period in ns; clk period is 10 ns

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs = 1'b1, spi_clk = 1'b0, spi_din = 1'b0;
  logic       spi_dout, spi_dout_oe;
  logic [9:0] ch0_data = 10'd0, ch1_data = 10'd0;
  logic       conv_done, frame_error;
  logic [2:0] conv_cfg;
  logic [9:0] conv_value;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_ferr = 0, n_both = 0;
  int base_done, base_ferr;

  logic rxb  [0:31];
  logic rxoe [0:31];

  always #5 clk = ~clk;

  mcp3002_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_din(spi_din), .spi_dout(spi_dout), .spi_dout_oe(spi_dout_oe),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .conv_done(conv_done),
    .conv_cfg(conv_cfg), .conv_value(conv_value), .frame_error(frame_error)
  );

  always @(posedge clk) begin
    if (conv_done) n_done++;
    if (frame_error) n_ferr++;
    if (conv_done && frame_error) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transaction. Rise index r: lead zeros, start, SGL, ODD,
  // MSBF, then ndata reads stored in rxb[r-lead-4] (rxb[0] = null bit).
  task automatic frame(input int lead, input logic sgl, input logic odd,
                       input logic msbf, input int ndata, input logic end_cs,
                       input logic chg);
    int   total;
    logic b;
    total = lead + 4 + ndata;
    spi_cs = 1'b0;
    #(HP);
    for (int r = 0; r < total; r++) begin
      if (r < lead)            b = 1'b0;
      else if (r == lead)      b = 1'b1;
      else if (r == lead + 1)  b = sgl;
      else if (r == lead + 2)  b = odd;
      else if (r == lead + 3)  b = msbf;
      else                     b = 1'b0;
      spi_din = b;
      #(HP);
      spi_clk = 1'b1;
      if (r >= lead + 4) begin
        rxb[r-lead-4]  = spi_dout;
        rxoe[r-lead-4] = spi_dout_oe;
      end
      if (chg && r == lead + 4) begin
        ch0_data = 10'd0;
        ch1_data = 10'd0;
      end
      #(HP);
      spi_clk = 1'b0;
    end
    #(HP);
    if (end_cs) spi_cs = 1'b1;
  endtask

  function automatic logic [31:0] word_msb(input int s);
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < 10; i++) w = {w[30:0], rxb[s+i]};
    return w;
  endfunction

  task automatic after_cs;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    chk("oe_after_cs", 32'(spi_dout_oe), 32'd0);
    chk("dout_after_cs", 32'(spi_dout), 32'd0);
    #(2*HP);
  endtask

  initial begin
    logic [31:0] lsbf;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", 32'(spi_dout_oe), 32'd0);
    chk("rst_dout", 32'(spi_dout), 32'd0);
    chk("rst_cfg", 32'(conv_cfg), 32'd0);
    chk("rst_value", 32'(conv_value), 32'd0);
    chk("rst_pulses", 32'(conv_done) | 32'(frame_error), 32'd0);
    rst = 1'b0;
    #(2*HP);

    // 1: single-ended CH0, MSB first
    ch0_data = 10'h2A5; ch1_data = 10'h111;
    base_done = n_done;
    frame(0, 1'b1, 1'b0, 1'b1, 13, 1'b1, 1'b0);
    chk("t1_null", 32'(rxb[0]), 32'd0);
    chk("t1_null_oe", 32'(rxoe[0]), 32'd1);
    chk("t1_word", word_msb(1), 32'h2A5);
    chk("t1_trail", 32'(rxb[11]) | 32'(rxb[12]), 32'd0);
    chk("t1_cfg", 32'(conv_cfg), 32'b101);
    chk("t1_value", 32'(conv_value), 32'h2A5);
    after_cs();
    chk("t1_done_cnt", 32'(n_done - base_done), 32'd1);

    // 2: single-ended CH1, LSB-first repeat
    ch0_data = 10'h0F0; ch1_data = 10'h301;
    base_done = n_done;
    frame(0, 1'b1, 1'b1, 1'b0, 22, 1'b1, 1'b0);
    chk("t2_word", word_msb(1), 32'h301);
    lsbf = 0;
    lsbf[0] = rxb[10];
    for (int i = 1; i < 10; i++) lsbf[i] = rxb[10+i];
    chk("t2_lsbf", lsbf, 32'h301);
    chk("t2_trail", 32'(rxb[20]) | 32'(rxb[21]), 32'd0);
    chk("t2_cfg", 32'(conv_cfg), 32'b110);
    after_cs();
    chk("t2_done_cnt", 32'(n_done - base_done), 32'd1);

    // 3: pseudo-differential, plain, clamped, and max
    ch0_data = 10'h200; ch1_data = 10'h0FF;
    frame(0, 1'b0, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("t3_diff", word_msb(1), 32'h101);
    chk("t3_cfg", 32'(conv_cfg), 32'b001);
    after_cs();
    ch0_data = 10'h0FF; ch1_data = 10'h200;
    frame(0, 1'b0, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("t3_clamp", word_msb(1), 32'h000);
    chk("t3_clamp_val", 32'(conv_value), 32'h000);
    after_cs();
    ch0_data = 10'h000; ch1_data = 10'h3FF;
    frame(0, 1'b0, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    chk("t3_swap_max", word_msb(1), 32'h3FF);
    after_cs();

    // 4: leading zeros; inputs change after the MSBF rise
    ch0_data = 10'h3FF; ch1_data = 10'h000;
    frame(3, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b1);
    chk("t4_null", 32'(rxb[0]), 32'd0);
    chk("t4_word", word_msb(1), 32'h3FF);
    after_cs();

    // 5: abort after the fifth data bit
    ch0_data = 10'h1C7;
    base_done = n_done; base_ferr = n_ferr;
    frame(0, 1'b1, 1'b0, 1'b1, 6, 1'b1, 1'b0);
    after_cs();
    chk("t5_ferr_cnt", 32'(n_ferr - base_ferr), 32'd1);
    chk("t5_no_done", 32'(n_done - base_done), 32'd0);
    ch0_data = 10'h155;
    frame(0, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("t5_next_word", word_msb(1), 32'h155);
    after_cs();

    // 6: reset in the middle of DATA
    ch0_data = 10'h2F0;
    base_ferr = n_ferr;
    frame(0, 1'b1, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe", 32'(spi_dout_oe), 32'd0);
    chk("t6_dout", 32'(spi_dout), 32'd0);
    chk("t6_cfg", 32'(conv_cfg), 32'd0);
    chk("t6_value", 32'(conv_value), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spi_cs = 1'b1;
    #(4*HP);
    chk("t6_no_ferr", 32'(n_ferr - base_ferr), 32'd0);
    ch0_data = 10'h0AB;
    frame(0, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    chk("t6_next_word", word_msb(1), 32'h0AB);
    chk("t6_next_cfg", 32'(conv_cfg), 32'b101);
    after_cs();

    chk("never_both", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
